// File: rtl/gather_dat.sv
// -----------------------------------------------------------------------------
// gather_dat
//
// Purpose:
//   Collects a stream of narrow CHUNK_W-bit beats into one wide word of
//   CHUNKS*CHUNK_W bits. Beat k of a word lands in chunk k, at bits
//   [(k+1)*CHUNK_W-1 : k*CHUNK_W]. This is the same column order the funnel
//   uses when it slices a wide word back into beats. The number of beats per
//   word is 1 << mode. mode is taken from t_cfg_dat on the first beat of each
//   word and clamped to log2(CHUNKS). Chunks beyond the word length read as
//   zero. A single output register with valid/ready handshaking lets a final
//   beat land in the same cycle that the previous word drains.
//
// Optional feature (macro GATHER_DAT_LAST_EN):
//   Adds the t_last input, which closes a word early, and the i_count output,
//   which reports the number of beats held in i_dat.
//
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high reset
//   t_dat      in   CHUNK_W  narrow beat data
//   t_valid    in   1        narrow beat valid
//   t_ready    out  1        beat accepted when t_valid & t_ready
//   t_last     in   1        (GATHER_DAT_LAST_EN) beat closes the word early
//   t_cfg_dat  in   8        requested beats-per-word exponent
//   i_dat      out  WIDE_W   assembled wide word
//   i_valid    out  1        wide word valid
//   i_ready    in   1        consumer ready
//   i_count    out  8        (GATHER_DAT_LAST_EN) beats held in i_dat
//   mode       out  8        clamped exponent of the current or last word
//   fill       out  8        beats held in the assembly register
// -----------------------------------------------------------------------------
module gather_dat #(
  parameter  int CHUNKS     = 4,
  parameter  int CHUNK_W    = 128,
  localparam int WIDE_W     = CHUNKS * CHUNK_W,
  localparam int LOG_CHUNKS = $clog2(CHUNKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHUNK_W-1:0] t_dat,
  input  logic              t_valid,
  output logic              t_ready,
`ifdef GATHER_DAT_LAST_EN
  input  logic              t_last,
  output logic [7:0]        i_count,
`endif
  input  logic [7:0]        t_cfg_dat,
  output logic [WIDE_W-1:0] i_dat,
  output logic              i_valid,
  input  logic              i_ready,
  output logic [7:0]        mode,
  output logic [7:0]        fill
);

  localparam logic [7:0] MAX_MODE = 8'(LOG_CHUNKS);

  logic [WIDE_W-1:0] r_asm;
  logic [WIDE_W-1:0] r_out;
  logic              r_out_valid;
  logic [7:0]        r_mode;
  logic [7:0]        r_fill;
`ifdef GATHER_DAT_LAST_EN
  logic [7:0]        r_count;
`endif

  logic [7:0]        w_mode_new;
  logic [7:0]        w_mode_eff;
  logic [7:0]        w_target;
  logic              w_active;
  logic              w_final;
  logic              w_stall;
  logic              w_acc;
  logic [WIDE_W-1:0] w_asm_next;

  always_comb begin
    // NOTE: every signal written here gets a default value first. A path that
    // leaves a signal unassigned would infer a latch.
    w_asm_next = r_asm;

    w_mode_new = (t_cfg_dat > MAX_MODE) ? MAX_MODE : t_cfg_dat;
    // The first beat of a word uses the live config. Later beats use the
    // latched value, so config changes in mid-word have no effect.
    w_mode_eff = (r_fill == 8'd0) ? w_mode_new : r_mode;
    w_target   = 8'd1 << w_mode_eff;
    w_active   = (r_fill != 8'd0) || t_valid;

`ifdef GATHER_DAT_LAST_EN
    w_final    = (r_fill == w_target - 8'd1) || (t_valid && t_last);
`else
    w_final    = (r_fill == w_target - 8'd1);
`endif

    // Only a final beat stalls, and only while the output register is full
    // and not draining this cycle. Non-final beats never need the output.
    w_stall    = w_final && w_active && r_out_valid && !i_ready;
    t_ready    = reset || !w_stall;
    w_acc      = t_valid && t_ready;

    for (int k = 0; k < CHUNKS; k++) begin
      if (r_fill == 8'(k)) w_asm_next[k*CHUNK_W +: CHUNK_W] = t_dat;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever the statement
  // order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide assembly register is reset as well as the control
      // state. Unwritten upper chunks rely on it holding zero.
      r_asm       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_mode      <= '0;
      r_fill      <= '0;
`ifdef GATHER_DAT_LAST_EN
      r_count     <= '0;
`endif
    end else begin
      if (r_out_valid && i_ready) r_out_valid <= 1'b0;

      if (w_acc) begin
        if (r_fill == 8'd0) r_mode <= w_mode_new;

        if (w_final) begin
          // The final beat goes straight into the output word. This assignment
          // overrides the drain clear above, so back-to-back words leave no
          // bubble on i_valid.
          r_out       <= w_asm_next;
          r_out_valid <= 1'b1;
          r_asm       <= '0;
          r_fill      <= '0;
`ifdef GATHER_DAT_LAST_EN
          r_count     <= r_fill + 8'd1;
`endif
        end else begin
          r_asm  <= w_asm_next;
          r_fill <= r_fill + 8'd1;
        end
      end
    end
  end

  assign i_dat   = r_out;
  assign i_valid = r_out_valid;
  assign mode    = r_mode;
  assign fill    = r_fill;
`ifdef GATHER_DAT_LAST_EN
  assign i_count = r_count;
`endif

endmodule
